// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The pipeline drives START/KILL/OP/DATA1/DATA2 and receives RESULT/BUSY/VALID.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic             KILL;
  logic [2:0]       OP;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [WIDTH-1:0] RESULT;
  logic             BUSY;
  logic             VALID;

  modport master (
    output START, KILL, OP, DATA1, DATA2,
    input  RESULT, BUSY, VALID
  );

  modport slave (
    input  START, KILL, OP, DATA1, DATA2,
    output RESULT, BUSY, VALID
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit.
// Multiply: operands are held for MUL_CYCLES cycles, and the product is taken on the last one.
// Divide: restoring radix-2 on magnitudes, one quotient bit per cycle, then one sign-fix cycle.
// Divide by zero and signed overflow skip the iteration and finish one cycle after the start.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input logic          CLK,
  input logic          RESET,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  logic [1:0]       r_fn;      // funct3[1:0] of the op in flight
  logic [WIDTH-1:0] r_a;       // multiplicand, or dividend/quotient shift register
  logic [WIDTH-1:0] r_b;       // multiplier, or divisor magnitude
  logic [WIDTH-1:0] r_rem;     // partial remainder
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_valid;

  // Launch-side decode, evaluated on the live request inputs.
  logic             w_accept;
  logic             w_sdiv_in;
  logic             w_neg_a_in;
  logic             w_neg_b_in;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  assign w_accept   = bus.START && !bus.KILL && (r_state == S_IDLE || r_state == S_DONE);
  assign w_sdiv_in  = !bus.OP[0];  // DIV/REM are signed, DIVU/REMU are not
  assign w_neg_a_in = w_sdiv_in && bus.DATA1[WIDTH-1];
  assign w_neg_b_in = w_sdiv_in && bus.DATA2[WIDTH-1];
  assign w_mag_a    = w_neg_a_in ? -bus.DATA1 : bus.DATA1;
  assign w_mag_b    = w_neg_b_in ? -bus.DATA2 : bus.DATA2;
  assign w_div0     = (bus.DATA2 == '0);
  assign w_ovf      = w_sdiv_in && (bus.DATA1 == MOST_NEG) && (bus.DATA2 == '1);

  // Multiply datapath on the held operands. MUL/MULH sign-extend both operands,
  // MULHSU only the first, MULHU neither; the low 2*WIDTH bits are exact either way.
  logic                 w_sa;
  logic                 w_sb;
  logic [2*WIDTH-1:0]   w_ext_a;
  logic [2*WIDTH-1:0]   w_ext_b;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_mul_res;

  assign w_sa      = (r_fn != 2'b11);
  assign w_sb      = !r_fn[1];
  assign w_ext_a   = {{WIDTH{w_sa && r_a[WIDTH-1]}}, r_a};
  assign w_ext_b   = {{WIDTH{w_sb && r_b[WIDTH-1]}}, r_b};
  assign w_prod    = w_ext_a * w_ext_b;
  assign w_mul_res = (r_fn == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

  // Divide datapath: one restoring step and the final sign fix.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_div_res;

  assign w_shift   = {r_rem, r_a[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_b};
  assign w_div_res = r_fn[1] ? (r_neg_r ? -r_rem : r_rem)
                             : (r_neg_q ? -r_a   : r_a);

  // Single-process FSM: control state, datapath registers and registered handshake outputs.
  // NOTE: every register here uses <= so all updates take the values from before the edge;
  // a blocking = would let later statements see half-updated state and break the shift/subtract step.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_fn     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (w_accept) begin
            r_fn   <= bus.OP[1:0];
            r_busy <= 1'b1;
            if (!bus.OP[2]) begin
              r_state <= S_MUL;
              r_a     <= bus.DATA1;
              r_b     <= bus.DATA2;
              r_cnt   <= CNT_W'(MUL_CYCLES - 1);
            end else begin
              r_state <= S_DIV;
              r_b     <= w_mag_b;
              if (w_div0) begin
                // Preload the architectural answers; the sign-fix cycle passes them through.
                r_a     <= '1;
                r_rem   <= bus.DATA1;
                r_cnt   <= '0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
              end else if (w_ovf) begin
                r_a     <= bus.DATA1;
                r_rem   <= '0;
                r_cnt   <= '0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
              end else begin
                r_a     <= w_mag_a;
                r_rem   <= '0;
                r_cnt   <= CNT_W'(WIDTH);
                r_neg_q <= w_neg_a_in ^ w_neg_b_in;
                r_neg_r <= w_neg_a_in;
              end
            end
          end
        end

        S_MUL: begin
          if (bus.KILL) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_result <= w_mul_res;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_valid  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_DIV: begin
          if (bus.KILL) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_result <= w_div_res;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_valid  <= 1'b1;
          end else begin
            r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_a   <= {r_a[WIDTH-2:0], !w_trial[WIDTH]};
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RESULT = r_result;
  assign bus.BUSY   = r_busy;
  assign bus.VALID  = r_valid;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle RV32M multiply/divide unit, parametrised in operand width. It is the successor to the single-cycle combinational ALU MUL/DIV paths. It covers all eight M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) behind a START/BUSY/VALID handshake. It sits beside the ALU in the EX stage; the pipeline stalls on BUSY and flushes via KILL.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, even)
MUL_CYCLES, 2, multiply latency in cycles from START edge to VALID (>=1)

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  reset, asynchronous, active-high
START  input  1  launch op; sampled only when not BUSY
KILL  input  1  abort in-flight op (pipeline flush)
OP  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
DATA1  input  WIDTH  rs1 operand (multiplicand/dividend)
DATA2  input  WIDTH  rs2 operand (multiplier/divisor)
RESULT  output  WIDTH  result, held until next completion
BUSY  output  1  op in progress, new START ignored
VALID  output  1  one-cycle pulse, RESULT valid this cycle

Behaviour:
- Clock CLK; reset RESET, asynchronous, active-high. While RESET is high: state=IDLE, RESULT=0, BUSY=0, VALID=0, all internal registers cleared. Reset mid-operation discards the op with no VALID.
- States: IDLE, MUL, DIV, DONE.
- Operand capture: OP/DATA1/DATA2 are registered at the accepting edge k. Inputs may change afterwards.
- START is accepted at edge k if state is IDLE or DONE and KILL=0. START while BUSY is ignored, with no queueing.
- Multiply path, IDLE->MUL:
  - The 2*WIDTH product uses sign extension per op: MUL/MULH signed x signed; MULHSU signed DATA1 x unsigned DATA2; MULHU unsigned x unsigned.
  - MUL returns the low WIDTH bits. MULH/MULHSU/MULHU return the high WIDTH bits.
  - Product is pipelined/counted so that MUL->DONE occurs at edge k+MUL_CYCLES.
- Divide path, IDLE->DIV:
  - Restoring radix-2 on magnitudes; 1 quotient bit per cycle, WIDTH iterations.
  - Then one sign-fix cycle: quotient negated if signs differ (signed ops); remainder takes the dividend's sign.
  - DIV->DONE at edge k+WIDTH+1.
- Special cases, fast path: DONE at edge k+1, no iteration.
  - Divisor=0: DIV/DIVU quotient = all ones; REM/REMU remainder = DATA1.
  - Signed overflow (DATA1 = most-negative, DATA2 = -1, DIV/REM only): quotient = DATA1, remainder = 0.
- DONE state: VALID=1, BUSY=0, RESULT updated on the entering edge.
  - Next edge goes to MUL/DIV if START is accepted, else IDLE, so back-to-back issue is allowed.
  - VALID is never high for 2 consecutive cycles unless a new op completes.
- BUSY=1 exactly in states MUL and DIV.
- KILL at any edge while BUSY: next state IDLE, no VALID, RESULT unchanged. KILL has priority over START in the same cycle. KILL in IDLE/DONE has no effect beyond blocking START.
- Width rules:
  - Arithmetic is two's complement modulo 2^WIDTH, with no X propagation.
  - The iteration counter is ceil(log2(WIDTH+1)) bits wide.
  - RESULT is updated only on entering DONE.

Test Plan:
- MUL 4x5 at WIDTH=32, MUL_CYCLES=2 -> VALID pulse at edge k+2, RESULT=20. BUSY high for exactly 2 cycles. MULH 131073x131073 -> RESULT=4.
- MULH 0xFFFFFFFE x 3 -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD at edge k+33. REM same operands -> 0xFFFFFFFF. DIVU same operands -> 0x7FFFFFFC. REMU 31/2 -> 1.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
  - All four above complete with VALID at edge k+1.
- Handshake and abort:
  - START during a DIV is ignored.
  - KILL at cycle 10 of a DIV -> IDLE, no VALID, RESULT keeps its prior value.
  - A START issued in the DONE cycle launches the next op back-to-back.
  - RESET asserted mid-DIV (asynchronously, between edges) -> RESULT/BUSY/VALID go to 0 immediately.
- Instance with WIDTH=8, MUL_CYCLES=1:
  - DIV 0x9C (-100) / 7 -> 0xF2 (-14) at edge k+9.
  - MULH 0x80 x 0x80 -> 0x40.
  - MUL 0x10 x 0x10 -> 0x00.
